// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction-memory port, IF/ID register out.
// The master side is the fetch stage; the slave side is the surrounding pipeline and memory.
interface fetch_stage_if;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        if_id_fault_o;
    logic        fetch_halted_o;

    modport master (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
        output imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
               if_id_valid_o, if_id_fault_o, fetch_halted_o
    );

    modport slave (
        output stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
        input  imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o,
               if_id_valid_o, if_id_fault_o, fetch_halted_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem address and
// registers the fetched word into IF/ID, with stall/flush/redirect and fault-halt handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } ifid_t;

    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);
    localparam ifid_t       BUBBLE  = '{pc: 32'h0, pc4: 32'h0, instr: NOP,
                                        valid: 1'b0, fault: 1'b0};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic        halted_q, halted_d;

    logic        fetch_fault;
    logic [31:0] pc_plus4;

    // Unsigned compare: addresses near 2^32 must fault, not wrap into range.
    assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);
    assign pc_plus4    = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            ifid_q   <= BUBBLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;

        if (bus.redirect_i) begin
            // Target is taken as-is; a misaligned target faults on its own fetch.
            pc_d    = bus.redirect_pc_i;
            ifid_d  = BUBBLE;
            state_d = ST_RUN;
        end else if (bus.flush_i) begin
            ifid_d = BUBBLE;
        end else if (bus.stall_i) begin
            ifid_d = ifid_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!fetch_fault) begin
                        ifid_d = '{pc: pc_q, pc4: pc_plus4, instr: bus.imem_instr_i,
                                   valid: 1'b1, fault: 1'b0};
                        pc_d   = pc_plus4;
                    end else begin
                        ifid_d  = '{pc: pc_q, pc4: pc_plus4, instr: NOP,
                                    valid: 1'b1, fault: 1'b1};
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    ifid_d = BUBBLE;
                end
                default: begin
                    ifid_d  = BUBBLE;
                    state_d = ST_RUN;
                end
            endcase
        end

        halted_d = (state_d == ST_HALT);
    end

    assign bus.imem_addr_o    = pc_q;
    assign bus.if_id_pc_o     = ifid_q.pc;
    assign bus.if_id_pc4_o    = ifid_q.pc4;
    assign bus.if_id_instr_o  = ifid_q.instr;
    assign bus.if_id_valid_o  = ifid_q.valid;
    assign bus.if_id_fault_o  = ifid_q.fault;
    assign bus.fetch_halted_o = halted_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. Owns the program counter, drives the combinational instruction-memory address, and registers the fetched word into the IF/ID pipeline register. Handles hazard-unit stalls, pipeline flushes, branch/jump redirects from EX, and halts fetch on an illegal fetch address until the next redirect. Upstream of decode; `Instr_mem` is its combinational, big-endian, byte-addressed memory port.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset.
- `MEM_SIZE`, 1024: instruction-memory size in bytes; bounds the legal fetch range.
- `NOP`, 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in 1: hazard unit requests hold of PC and IF/ID.
- `flush_i` in 1: replace IF/ID with a bubble and re-fetch the current PC.
- `redirect_i` in 1: taken branch or jump resolved in EX.
- `redirect_pc_i` in 32: redirect target.
- `imem_addr_o` out 32: fetch address; always equals the PC register.
- `imem_instr_i` in 32: instruction word returned combinationally for `imem_addr_o`.
- `if_id_pc_o` out 32: PC of the IF/ID instruction.
- `if_id_pc4_o` out 32: `if_id_pc_o + 4`.
- `if_id_instr_o` out 32: instruction word.
- `if_id_valid_o` out 1: IF/ID holds a real instruction.
- `if_id_fault_o` out 1: IF/ID entry is an instruction-fetch fault.
- `fetch_halted_o` out 1: FSM is in HALT.

## Operation
- Fault condition, evaluated on the current PC: `pc[1:0] != 0` or `pc > MEM_SIZE-4`. Use a 32-bit unsigned compare. `imem_instr_i` is ignored when the fault condition is true.
- FSM states:
  - RUN: normal fetch.
  - HALT: entered after a faulting fetch is registered. It is left only by `redirect_i`.
- Per rising edge, first matching rule applies:
  1. `redirect_i`:
     - PC <= `redirect_pc_i`, unmodified; alignment is checked on the next fetch.
     - IF/ID <= bubble.
     - state <= RUN.
     - This rule applies in any state and overrides `stall_i` and `flush_i`.
  2. `flush_i`: IF/ID <= bubble; PC and state unchanged.
  3. `stall_i`: PC, IF/ID and state all held.
  4. RUN with no fault:
     - IF/ID <= {pc, pc+4, `imem_instr_i`, valid=1, fault=0}.
     - PC <= pc+4, wrapping modulo 2^32.
  5. RUN with fault:
     - IF/ID <= {pc, pc+4, NOP, valid=1, fault=1}.
     - PC held.
     - state <= HALT.
  6. HALT: IF/ID <= bubble; PC held.
- Bubble definition: pc=0, pc4=0, instr=NOP, valid=0, fault=0.
- `fetch_halted_o` is 1 exactly when the state is HALT; it is a registered output.

## Timing
- Reset (async assert, synchronous to `clk` on release):
  - PC = `RESET_PC`, so `imem_addr_o = RESET_PC`.
  - state = RUN.
  - IF/ID = bubble.
  - `fetch_halted_o` = 0.
- Latency:
  - The instruction at PC p appears on IF/ID one cycle after p is driven on `imem_addr_o`.
  - The first valid IF/ID entry appears at the first rising edge after reset release, unless that cycle is stalled.
- Throughput: one instruction per cycle when there are no stalls.
- Redirect penalty: the IF/ID entry one cycle after `redirect_i` is a bubble. The target instruction is valid on the second edge after the redirect cycle.
- `stall_i` held for N cycles freezes IF/ID outputs for N cycles. No entry is lost or duplicated.
- The faulting entry is presented exactly once. `if_id_fault_o` is never 1 together with `if_id_valid_o` = 0.
- HALT plus `stall_i`: everything is held. HALT plus `flush_i`: a bubble is loaded, which the HALT state also requires.
- All outputs are registered except `imem_addr_o`, which is a wire from the PC register.

## Test plan
- Reset, then run free:
  - With `rst_n` low, `imem_addr_o` = 0, `if_id_valid_o` = 0 and `if_id_instr_o` = 0x00000013.
  - After release, memory words 0x00500093, 0x00A00113 appear at pc 0 and pc 4 on consecutive cycles, with `if_id_pc4_o` = 4 and 8.
- `stall_i` high for 3 cycles at pc=0x8: `imem_addr_o` stays 0x8 and IF/ID stays the pc=0x4 entry for 3 cycles. The pc=0x8 entry follows with no gap and no duplicate.
- `redirect_i` with `redirect_pc_i`=0x40 asserted together with `stall_i` and `flush_i`:
  - Next cycle: `imem_addr_o` = 0x40 and IF/ID is a bubble.
  - The cycle after: `if_id_pc_o` = 0x40 with valid=1.
- Range fault with `MEM_SIZE`=1024:
  - Fetch at 0x3FC is valid.
  - Fetch at 0x400 gives valid=1, fault=1, instr=NOP, and `fetch_halted_o`=1 on the following cycle.
  - Subsequent entries are bubbles while `imem_addr_o` stays at 0x400.
  - A redirect to 0x0 resumes fetch.
- Misaligned redirect to 0x102: exactly one fault entry with `if_id_pc_o`=0x102, then HALT.
- `flush_i` for 1 cycle at pc=0x10: IF/ID becomes a bubble, then the pc=0x10 entry is re-fetched. No PC is skipped.
